// File: rtl/fifo_push_arbiter.sv
// Round-robin, packet-locking push arbiter that shares one Fifo between several val/rdy
// producers, tags each beat with its source index and exposes the Fifo head to one consumer.
module fifo_push_arbiter #(
    parameter int unsigned p_num_reqs = 4,
    parameter int unsigned p_msg_bits = 32,
    parameter int unsigned p_depth    = 32,
    localparam int unsigned c_id_bits  = $clog2(p_num_reqs),
    localparam int unsigned c_cnt_bits = $clog2(p_depth + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_num_reqs-1:0]          req_val,
    output logic [p_num_reqs-1:0]          req_rdy,
    input  logic [p_num_reqs-1:0]          req_last,
    input  logic [p_num_reqs*p_msg_bits-1:0] req_msg,
    output logic                           fifo_push,
    output logic [c_id_bits+p_msg_bits-1:0] fifo_wdata,
    input  logic                           fifo_full,
    output logic                           fifo_pop,
    input  logic                           fifo_empty,
    input  logic [c_id_bits+p_msg_bits-1:0] fifo_rdata,
    output logic                           deq_val,
    input  logic                           deq_rdy,
    output logic [c_id_bits-1:0]           deq_src,
    output logic [p_msg_bits-1:0]          deq_msg,
    output logic [c_cnt_bits-1:0]          occupancy
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q;
    logic [c_id_bits-1:0]  ptr_q;
    logic [c_id_bits-1:0]  owner_q;
    logic [c_cnt_bits-1:0] count_q;

    logic [c_id_bits-1:0]  winner;
    logic                  found;
    logic [c_id_bits-1:0]  grant;
    logic                  grant_en;
    logic [c_id_bits-1:0]  next_ptr;

    // Descending scan so the candidate closest to ptr_q is written last and wins.
    always_comb begin
        logic [c_id_bits-1:0] idx;
        winner = '0;
        found  = 1'b0;
        for (int k = int'(p_num_reqs) - 1; k >= 0; k--) begin
            idx = c_id_bits'((int'(ptr_q) + k) % int'(p_num_reqs));
            if (req_val[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant    = (state_q == StLocked) ? owner_q : winner;
        grant_en = (state_q == StLocked) ? 1'b1 : found;
        next_ptr = (grant == c_id_bits'(p_num_reqs - 1)) ? '0 : grant + c_id_bits'(1);

        req_rdy = '0;
        if (!rst && grant_en && !fifo_full) begin
            req_rdy[grant] = 1'b1;
        end
        fifo_push  = req_val[grant] & req_rdy[grant];
        fifo_wdata = {grant, req_msg[grant*p_msg_bits +: p_msg_bits]};
    end

    always_comb begin
        deq_val              = !fifo_empty;
        fifo_pop             = deq_val & deq_rdy & !rst;
        {deq_src, deq_msg}   = fifo_rdata;
        occupancy            = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            if (fifo_push) begin
                if (req_last[grant]) begin
                    ptr_q   <= next_ptr;
                    state_q <= StIdle;
                end else if (state_q == StIdle) begin
                    owner_q <= grant;
                    state_q <= StLocked;
                end
            end
            unique case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + c_cnt_bits'(1);
                2'b01:   count_q <= count_q - c_cnt_bits'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomised scoreboard bench for fifo_push_arbiter with a behavioural Fifo attached.
module tb_fifo_push_arbiter;

    localparam int N     = 4;
    localparam int MB    = 32;
    localparam int DEPTH = 4;
    localparam int IDB   = 2;
    localparam int CB    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_val, req_rdy, req_last;
    logic [N*MB-1:0]   req_msg;
    logic              fifo_push, fifo_full, fifo_pop, fifo_empty;
    logic [IDB+MB-1:0] fifo_wdata, fifo_rdata;
    logic              deq_val, deq_rdy;
    logic [IDB-1:0]    deq_src;
    logic [MB-1:0]     deq_msg;
    logic [CB-1:0]     occupancy;

    always #5 clk = ~clk;

    fifo_push_arbiter #(.p_num_reqs(N), .p_msg_bits(MB), .p_depth(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_val(req_val), .req_rdy(req_rdy), .req_last(req_last),
        .req_msg(req_msg), .fifo_push(fifo_push), .fifo_wdata(fifo_wdata),
        .fifo_full(fifo_full), .fifo_pop(fifo_pop), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_src(deq_src),
        .deq_msg(deq_msg), .occupancy(occupancy)
    );

    // Behavioural Fifo with registered write, reset by the same rst.
    logic [IDB+MB-1:0] mem [DEPTH];
    int f_rd, f_wr, f_cnt;
    assign fifo_full  = (f_cnt == DEPTH);
    assign fifo_empty = (f_cnt == 0);
    assign fifo_rdata = mem[f_rd];
    always @(posedge clk) begin
        if (rst) begin
            f_rd <= 0; f_wr <= 0; f_cnt <= 0;
        end else begin
            if (fifo_push && !fifo_full) begin
                mem[f_wr] <= fifo_wdata;
                f_wr <= (f_wr + 1) % DEPTH;
            end
            if (fifo_pop && !fifo_empty) f_rd <= (f_rd + 1) % DEPTH;
            f_cnt <= f_cnt + ((fifo_push && !fifo_full) ? 1 : 0) - ((fifo_pop && !fifo_empty) ? 1 : 0);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, optional lock owner, entry count, expected order.
    int                m_ptr = 0, m_owner = 0, m_cnt = 0;
    bit                m_locked = 0;
    logic [IDB+MB-1:0] sb[$];
    int                last_mode = 0;   // 0 random, 1 always last, 2 never last
    int                regen = -1;

    task automatic new_beat(input int i);
        req_msg[i*MB +: MB] = {i[7:0], 24'($urandom)};
        req_last[i] = (last_mode == 1) ? 1'b1 : (last_mode == 2) ? 1'b0 : 1'($urandom_range(0, 2) == 0);
    endtask

    // One clock: check DUT against the model at negedge, advance the model, end at posedge+1.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int  g;
        bit  have, mpush, mpop;
        @(negedge clk);
        exp_rdy = '0; mpush = 0; mpop = 0; have = 0; g = 0;
        if (!rst) begin
            if (m_locked) begin
                g = m_owner; have = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr + k) % N;
                    if (!have && req_val[i]) begin g = i; have = 1; end
                end
            end
            if (have && m_cnt < DEPTH) exp_rdy[g] = 1'b1;
            mpush = have && (m_cnt < DEPTH) && req_val[g];
            mpop  = (m_cnt > 0) && deq_rdy;
        end
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        check("fifo_push", 64'(fifo_push), 64'(mpush));
        check("fifo_pop", 64'(fifo_pop), 64'(mpop));
        check("occupancy", 64'(occupancy), 64'(m_cnt));
        check("deq_val", 64'(deq_val), 64'(m_cnt != 0));
        check("full_vs_occ", 64'(fifo_full), 64'(occupancy == CB'(DEPTH)));
        check("empty_vs_occ", 64'(fifo_empty), 64'(occupancy == '0));
        if (rst) begin
            m_cnt = 0; m_ptr = 0; m_locked = 0; m_owner = 0;
            sb.delete();
        end else begin
            if (mpush) begin
                logic [IDB-1:0] gi;
                gi = IDB'(g);
                sb.push_back({gi, req_msg[g*MB +: MB]});
                if (req_last[g]) begin
                    m_ptr = (g + 1) % N; m_locked = 0;
                end else begin
                    m_owner = g; m_locked = 1;
                end
                regen = g;
            end
            m_cnt = m_cnt + (mpush ? 1 : 0) - (mpop ? 1 : 0);
        end
        @(posedge clk);
        #1;
        if (regen >= 0) begin new_beat(regen); regen = -1; end
    endtask

    // Monitor: every consumer handshake must deliver the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && deq_val && deq_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_deq", 64'(deq_val), 64'(0));
            end else begin
                logic [IDB+MB-1:0] e;
                e = sb.pop_front();
                check("deq_src", 64'(deq_src), 64'(e[IDB+MB-1:MB]));
                check("deq_msg", 64'(deq_msg), 64'(e[MB-1:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; req_val = '0; deq_rdy = 1'b0;
        req_last = '0; req_msg = '0;
        last_mode = 1;
        for (int i = 0; i < N; i++) new_beat(i);
        #1;
        step(); step();
        rst = 1'b0;

        // Single beat held in the Fifo, then popped.
        req_msg[0 +: MB] = 32'hdeadbeef; req_last[0] = 1'b1;
        req_val = 4'b0001;
        step();
        req_val = '0;
        step(); step();
        deq_rdy = 1'b1;
        step(); step();

        // Round robin with all producers valid and single-beat packets.
        req_val = 4'b1111;
        repeat (10) step();
        req_val = '0;
        repeat (6) step();

        // Full backpressure from producer 3, then a one-cycle pop pulse.
        deq_rdy = 1'b0; req_val = 4'b1000;
        repeat (7) step();
        deq_rdy = 1'b1; step();
        deq_rdy = 1'b0; repeat (3) step();
        req_val = '0; deq_rdy = 1'b1;
        repeat (6) step();

        // Packet lock on producer 1 with competitors and a bubble.
        last_mode = 2; new_beat(1);
        req_val = 4'b0111; step(); step();
        req_val = 4'b0101; step();
        last_mode = 1; req_last[1] = 1'b1;
        req_val = 4'b0111;
        repeat (5) step();
        req_val = '0; repeat (5) step();

        // Reset mid-packet, then ptr must be back at 0.
        last_mode = 2; new_beat(2);
        deq_rdy = 1'b0; req_val = 4'b0100; step();
        rst = 1'b1; step();
        rst = 1'b0; last_mode = 1;
        for (int i = 0; i < N; i++) new_beat(i);
        req_val = 4'b0110; repeat (3) step();
        req_val = '0; deq_rdy = 1'b1; repeat (5) step();

        // Random traffic with occasional resets.
        last_mode = 0;
        repeat (3000) begin
            req_val = N'($urandom);
            deq_rdy = 1'($urandom_range(0, 3) != 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; req_val = '0; deq_rdy = 1'b1;
        repeat (DEPTH + 4) step();
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
